// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: configurable UART receiver feeding a first-word-fall-through receive FIFO
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 781250,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx_i,
  input  logic                              rx_en_i,
  input  logic                              clr_i,
  output logic [DATA_BITS-1:0]              rd_data_o,
  output logic                              rd_perr_o,
  output logic                              rd_ferr_o,
  output logic                              rd_valid_o,
  input  logic                              rd_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill_o,
  output logic                              overflow_o,
  output logic                              busy_o
);
  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = $clog2(DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  localparam logic [FW-1:0] DEPTH = FW'(FIFO_DEPTH);
  localparam logic PODD = PARITY_ODD != 0;

  if (DIV < 4) begin : g_div_check
    $error("uart_rx_fifo: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 rx_meta, rx_s;
  logic [CW-1:0]        cnt;
  logic [3:0]           bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr;
  logic                 push, pop, wr;
  logic [EW-1:0]        entry;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [FW-1:0]        fill;
  logic                 overflow;

  // two-flop synchroniser on the asynchronous line, idling high
  always_ff @(posedge clk) begin
    if (!rst_n) {rx_s, rx_meta} <= 2'b11;
    else {rx_s, rx_meta} <= {rx_meta, rx_i};
  end

  // frame FSM: mid-bit sampling via a down-counter reloaded at each sample point
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      state <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      shreg <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else if (state != IDLE && !rx_en_i) state <= IDLE;
    else if (state == IDLE) begin
      if (rx_en_i && !rx_s) begin
        state <= START;
        cnt <= HALF;
        bcnt <= '0;
        perr <= 1'b0;
        ferr <= 1'b0;
      end
    end else if (cnt != '0) cnt <= cnt - CW'(1);
    else begin
      cnt <= RELOAD;
      bcnt <= bcnt + 4'd1;
      case (state)
        START: begin
          state <= rx_s ? IDLE : DATA;
          bcnt <= '0;
        end
        DATA: begin
          shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          if (bcnt == LAST_D) begin
            state <= PARITY_EN != 0 ? PARITY : STOP;
            bcnt <= '0;
          end
        end
        PARITY: begin
          perr <= ^{shreg, rx_s, PODD};
          state <= STOP;
          bcnt <= '0;
        end
        STOP: begin
          ferr <= ferr | ~rx_s;
          if (bcnt == LAST_S) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // push on the final stop sample; a full FIFO only accepts when popping in the same cycle
  always_comb begin
    push = rx_en_i && state == STOP && cnt == '0 && bcnt == LAST_S;
    entry = {ferr | ~rx_s, perr, shreg};
    pop = rd_valid_o && rd_ready_i;
    wr = push && (fill != DEPTH || pop);
  end

  // FIFO storage, pointers, fill count and sticky overflow; flush beats push and pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
      overflow <= 1'b0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= entry;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fill <= fill + FW'(wr) - FW'(pop);
      if (push && fill == DEPTH && !pop) overflow <= 1'b1;
    end
  end

  assign {rd_ferr_o, rd_perr_o, rd_data_o} = mem[rd_ptr];
  assign rd_valid_o = fill != '0;
  assign fill_o = fill;
  assign overflow_o = overflow;
  assign busy_o = state != IDLE;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised, synthesisable UART receiver with a receive FIFO. It generalises the fixed 8N1 UART bus model used at pad level to configurable data width, parity and stop bits, and adds per-character error flags, overflow detection and flush. It sits between the `uart_tx` pad of `pulpino_top_pads` and FPGA-side or on-chip logic that consumes the console output. All control is sampled on `clk`.

## Interface
- `CLK_FREQ_HZ`, 25000000, `clk` frequency.
- `BAUD_RATE`, 781250, line rate. `DIV = CLK_FREQ_HZ/BAUD_RATE` (integer division). Elaboration fails if `DIV < 4`.
- `DATA_BITS`, 8, character width, 5..9, LSB first on the line.
- `PARITY_EN`, 0, 1 = one parity bit follows the data bits.
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity.
- `STOP_BITS`, 1, 1 or 2.
- `FIFO_DEPTH`, 16, number of entries, power of two, at least 2.
- `clk`, in, 1, the single clock.
- `rst_n`, in, 1, reset. Synchronous, active-low.
- `rx_i`, in, 1, asynchronous serial input, idle high.
- `rx_en_i`, in, 1, receiver enable.
- `clr_i`, in, 1, one-cycle flush request.
- `rd_data_o`, out, DATA_BITS, head-of-FIFO character.
- `rd_perr_o`, out, 1, parity error flag of the head entry.
- `rd_ferr_o`, out, 1, framing error flag of the head entry.
- `rd_valid_o`, out, 1, FIFO is non-empty.
- `rd_ready_i`, in, 1, pop the head entry when asserted together with `rd_valid_o`.
- `fill_o`, out, $clog2(FIFO_DEPTH+1), current number of entries.
- `overflow_o`, out, 1, sticky flag: a character was dropped.
- `busy_o`, out, 1, receiver is not in IDLE.

## Operation
- **Input synchroniser.** `rx_i` passes through a 2-FF synchroniser to give `rx_s`. Both flops reset to 1.
- **FSM states.** IDLE, START, DATA, PARITY, STOP. There is one bit counter and one down-counter `cnt` of width $clog2(DIV).
- **IDLE.** When `rx_en_i`=1 and `rx_s`=0, load `cnt`=DIV/2-1 and go to START. That cycle is the detection cycle T.
- **Sampling points.** `cnt` decrements every cycle. When `cnt`=0, sample `rx_s` and reload `cnt`=DIV-1.
- **START.** If the sample is 1, treat it as a false start and return to IDLE with nothing pushed. Otherwise go to DATA.
- **DATA.** Take DATA_BITS samples into the shift register, LSB first. Then go to PARITY if `PARITY_EN`=1, else to STOP.
- **PARITY.** `perr` = (XOR of the data bits XOR the sampled parity bit XOR `PARITY_ODD`) != 0.
- **STOP.** Take STOP_BITS samples. `ferr` = 1 if any stop sample is 0.
- **Push.** On the final stop sample, push {ferr, perr, data} and return to IDLE in the same cycle. A new start bit can therefore be detected one cycle later.
- **FIFO.** First-word-fall-through. Head outputs come directly from storage indexed by the read pointer.
  - A pop occurs when `rd_valid_o` & `rd_ready_i`.
  - A push when full with no pop drops the character and sets `overflow_o`. The FIFO contents are unchanged.
  - A push when full with a pop in the same cycle is accepted: `fill_o` stays at FIFO_DEPTH and there is no overflow.
  - A push and pop on a non-empty FIFO leave `fill_o` unchanged.
  - A push into an empty FIFO: `rd_valid_o` rises the next cycle.
- **`clr_i`.**
  - Empties the FIFO and clears `overflow_o`.
  - Aborts the FSM to IDLE.
  - Has priority over a push or pop in the same cycle; that character is lost and `overflow_o` is not set.
- **`rx_en_i` deasserted mid-frame.** The FSM returns to IDLE on the next cycle and nothing is pushed. FIFO contents are kept.
- **Reset.** While `rst_n`=0 at a clock edge:
  - FSM goes to IDLE and pointers go to 0.
  - `rd_valid_o`=0, `fill_o`=0, `overflow_o`=0, `busy_o`=0.
  - `rd_data_o`, `rd_perr_o`, `rd_ferr_o` = 0. Storage is reset to 0.
  - A reset mid-frame discards the partial character.

## Timing
- **Synchroniser latency.** A falling pad edge is seen on `rx_s` 2 cycles later. The detection cycle is T.
- **Sample cycles.**
  - Start bit at T+DIV/2.
  - Data bit k (k = 0..DATA_BITS-1) at T+DIV/2+(k+1)·DIV.
  - Parity, if enabled, one DIV after the last data bit. Stop bits follow, each one DIV apart.
- **8N1 with DIV=32.** The last stop sample and push occur at T+304. `rd_valid_o` and `fill_o` update at T+305.
- **Pop.** Registered. `fill_o` and the head update on the cycle after a pop.
- **`busy_o`.** High from T+1 through the push cycle.

## Test plan
- **Basic character.** Defaults, send 0xA5 8N1 at 781250 baud. Expect `rd_valid_o` at T+305, `rd_data_o`=0xA5, `rd_perr_o`=0, `rd_ferr_o`=0, `fill_o`=1.
- **Parity.** `PARITY_EN`=1, `PARITY_ODD`=0, `DATA_BITS`=7. Send 0x41 with a correct parity bit, then 0x41 with a flipped parity bit. Expect two entries with `rd_perr_o`=0 then 1, data 0x41 in both.
- **Framing and glitch.** Send 0x3C with the stop bit forced low. Expect `rd_ferr_o`=1 and data 0x3C. Then apply a 5-cycle low glitch on `rx_i`. Expect no push and `busy_o` back to 0 by T+DIV/2+1.
- **Overflow.** `FIFO_DEPTH`=4, `rd_ready_i`=0, send 0x01..0x05. Expect `fill_o`=4 and `overflow_o`=1. Popping yields 0x01..0x04.
- **Push while full with pop.** With the FIFO full, hold `rd_ready_i`=1 so that a pop coincides with a push. Expect no overflow and `fill_o` to stay at 4.
- **Clear and reset mid-frame.** Pulse `clr_i` during the data bits of a character, with 2 entries queued. Expect `fill_o`=0, `overflow_o`=0, that character lost, and the next character received correctly. Then assert `rst_n`=0 mid-frame. Expect all outputs 0 on the next edge.
